// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module : pong_pkg
// Brief  : Shared VGA timing, tile and colour constants for the playfield.
// Rev    : 1.0
// ============================================================================
package pong_pkg;

    localparam int VGA_CLK_DIV  = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_TILE_SHIFT = 4;
    localparam int VGA_WALL_TOP   = 5;
    localparam int VGA_WALL_BOT   = 29;

    localparam logic [11:0] COL_BLANK = 12'h000;
    localparam logic [11:0] COL_BG    = 12'h000;
    localparam logic [11:0] COL_BALL  = 12'hFFF;
    localparam logic [11:0] COL_PADL  = 12'hF00;
    localparam logic [11:0] COL_PADR  = 12'h00F;
    localparam logic [11:0] COL_WALL  = 12'h888;

    localparam logic [5:0] TILE_OFFGRID = 6'd63;

    typedef struct packed {
        logic ball;
        logic padl;
        logic padr;
    } draw_t;

    // First match wins; blanking overrides every object reply.
    function automatic logic [11:0] pixel_color(
        input logic        video_on,
        input draw_t       draw,
        input logic        wall,
        input logic [11:0] bg
    );
        if (!video_on)      return COL_BLANK;
        else if (draw.ball) return COL_BALL;
        else if (draw.padl) return COL_PADL;
        else if (draw.padr) return COL_PADR;
        else if (wall)      return COL_WALL;
        else                return bg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_tile_scanner_if.sv
`default_nettype none
// ============================================================================
// Module : vga_tile_scanner_if
// Brief  : Object-block interface: tile coordinates out, draw replies in, VGA pins.
// Rev    : 1.0
// ============================================================================
interface vga_tile_scanner_if;
    logic        draw_ball;
    logic        draw_paddle_l;
    logic        draw_paddle_r;
    logic [5:0]  counter_x;
    logic [5:0]  counter_y;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [11:0] rgb;
    logic        frame_tick;

    modport master (
        input  draw_ball, draw_paddle_l, draw_paddle_r,
        output counter_x, counter_y, hsync, vsync, video_on, rgb, frame_tick
    );

    modport slave (
        output draw_ball, draw_paddle_l, draw_paddle_r,
        input  counter_x, counter_y, hsync, vsync, video_on, rgb, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/vga_tile_scanner_timing.sv
`default_nettype none
// ============================================================================
// Module : vga_timing
// Brief  : Pixel-rate divider, h/v raster counters, raw sync/active flags.
// Rev    : 1.0
// ============================================================================
module vga_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic            pix_en_o,
    output logic [9:0]      h_cnt_o,
    output logic [9:0]      v_cnt_o,
    output logic            active_o,
    output logic            hsync_on_o,
    output logic            vsync_on_o,
    output logic            frame_tick_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             pix_en;

    assign pix_en = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = pix_en ? '0 : div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    assign pix_en_o     = pix_en;
    assign h_cnt_o      = h_cnt_q;
    assign v_cnt_o      = v_cnt_q;
    assign active_o     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hsync_on_o   = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vsync_on_o   = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    assign frame_tick_o = pix_en && (h_cnt_q == '0) && (v_cnt_q == V_ACT);
endmodule
`default_nettype wire

// File: rtl/vga_tile_scanner.sv
`default_nettype none
// ============================================================================
// Module : vga_tile_scanner
// Brief  : Tile-coordinate raster scanner with 2-stage draw-reply compositing.
// Rev    : 1.0
// ============================================================================
module vga_tile_scanner
    import pong_pkg::*;
#(
    parameter int          CLK_DIV    = VGA_CLK_DIV,
    parameter int          H_ACTIVE   = VGA_H_ACTIVE,
    parameter int          H_FP       = VGA_H_FP,
    parameter int          H_SYNC     = VGA_H_SYNC,
    parameter int          H_BP       = VGA_H_BP,
    parameter int          V_ACTIVE   = VGA_V_ACTIVE,
    parameter int          V_FP       = VGA_V_FP,
    parameter int          V_SYNC     = VGA_V_SYNC,
    parameter int          V_BP       = VGA_V_BP,
    parameter int          TILE_SHIFT = VGA_TILE_SHIFT,
    parameter int          WALL_TOP   = VGA_WALL_TOP,
    parameter int          WALL_BOT   = VGA_WALL_BOT,
    parameter logic [11:0] BG_COLOR   = COL_BG
) (
    input  wire logic          clk,
    input  wire logic          rst,
    vga_tile_scanner_if.master bus
);
    logic       pix_en, active, hsync_on, vsync_on, frame_tick;
    logic [9:0] h_cnt, v_cnt;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .pix_en_o    (pix_en),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active),
        .hsync_on_o  (hsync_on),
        .vsync_on_o  (vsync_on),
        .frame_tick_o(frame_tick)
    );

    // Stage 0: tile coordinates presented to the object blocks
    logic       act0_q, hs0_q, vs0_q;
    logic [5:0] cx_q, cx_d, cy_q, cy_d;
    // Stage 1: pixel-aligned VGA outputs
    logic        hsync_q, vsync_q, video_q;
    logic [11:0] rgb_q, rgb_d;
    logic        wall;
    draw_t       draw;

    always_comb begin
        cx_d = active ? 6'(h_cnt >> TILE_SHIFT) : TILE_OFFGRID;
        cy_d = active ? 6'(v_cnt >> TILE_SHIFT) : TILE_OFFGRID;
    end

    // The stage-0 tile row doubles as the wall-row key for stage 1.
    assign wall  = (cy_q == 6'(WALL_TOP)) || (cy_q == 6'(WALL_BOT));
    assign draw  = '{ball: bus.draw_ball, padl: bus.draw_paddle_l, padr: bus.draw_paddle_r};
    assign rgb_d = pixel_color(act0_q, draw, wall, BG_COLOR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act0_q  <= 1'b0;
            hs0_q   <= 1'b0;
            vs0_q   <= 1'b0;
            cx_q    <= TILE_OFFGRID;
            cy_q    <= TILE_OFFGRID;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            rgb_q   <= COL_BLANK;
        end else if (pix_en) begin
            act0_q  <= active;
            hs0_q   <= hsync_on;
            vs0_q   <= vsync_on;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            hsync_q <= ~hs0_q;
            vsync_q <= ~vs0_q;
            video_q <= act0_q;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.counter_x  = cx_q;
    assign bus.counter_y  = cy_q;
    assign bus.hsync      = hsync_q;
    assign bus.vsync      = vsync_q;
    assign bus.video_on   = video_q;
    assign bus.rgb        = rgb_q;
    assign bus.frame_tick = frame_tick;
endmodule
`default_nettype wire

// File: tb/tb_vga_tile_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_tile_scanner
// Brief  : Scoreboard bench on a shrunken raster (4x3 tile grid).
// Rev    : 1.0
// ============================================================================
module tb_vga_tile_scanner;
    localparam int D  = 4;
    localparam int HA = 64, HF = 8, HS = 8, HB = 8;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3;
    localparam int WT = 1, WB = 2;
    localparam logic [11:0] BG = 12'h012;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    typedef struct packed {
        logic [5:0]  cx;
        logic [5:0]  cy;
        logic        hs;
        logic        vs;
        logic        vid;
        logic        ft;
        logic [11:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    vga_tile_scanner_if bus ();

    vga_tile_scanner #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .TILE_SHIFT(4), .WALL_TOP(WT), .WALL_BOT(WB), .BG_COLOR(BG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic force_all = 1'b0;
    logic track_vs = 1'b0;
    int   vs_fall = -1;

    // Expected outputs after c clock edges since reset release.
    function automatic exp_t exp_at(input int c);
        exp_t e;
        int p, px, h, v;
        logic [5:0] tx, ty;
        logic frc, b, pl, pr;
        e = '{cx: 6'd63, cy: 6'd63, hs: 1'b1, vs: 1'b1, vid: 1'b0, ft: 1'b0, rgb: 12'h000};
        p = c / D;
        e.ft = ((c % D) == D - 1) && ((p % FR) == VA * HT);
        px = p - 1;
        if (px >= 0) begin
            h = px % HT;
            v = (px / HT) % VT;
            if (h < HA && v < VA) begin
                e.cx = 6'(h / 16);
                e.cy = 6'(v / 16);
            end
        end
        px = p - 2;
        if (px >= 0) begin
            h = px % HT;
            v = (px / HT) % VT;
            e.hs  = !(h >= HA + HF && h < HA + HF + HS);
            e.vs  = !(v >= VA + VF && v < VA + VF + VS);
            e.vid = (h < HA && v < VA);
            if (e.vid) begin
                tx  = 6'(h / 16);
                ty  = 6'(v / 16);
                frc = ((px / FR) == 1);
                b   = frc || (tx == 6'd2 && ty == 6'd1);
                pl  = frc || (tx == 6'd1 && ty == 6'd0);
                pr  = frc || (tx == 6'd1 && ty == 6'd0) || (tx == 6'd3 && ty == 6'd0);
                if (b)                           e.rgb = 12'hFFF;
                else if (pl)                     e.rgb = 12'hF00;
                else if (pr)                     e.rgb = 12'h00F;
                else if (ty == WT || ty == WB)   e.rgb = 12'h888;
                else                             e.rgb = BG;
            end
        end
        return e;
    endfunction

    // Advance n clocks; ball/paddle replies follow the presented tile one clk later.
    task automatic run(input int n);
        int p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            q.push_back(exp_at(cyc));
            p = cyc / D;
            force_all = (p >= FR - 2 * HT) && (p < 2 * FR - 2 * HT);
            bus.draw_ball     = force_all || (bus.counter_x == 6'd2 && bus.counter_y == 6'd1);
            bus.draw_paddle_l = force_all || (bus.counter_x == 6'd1 && bus.counter_y == 6'd0);
            bus.draw_paddle_r = force_all || (bus.counter_x == 6'd1 && bus.counter_y == 6'd0)
                                          || (bus.counter_x == 6'd3 && bus.counter_y == 6'd0);
            if (track_vs && vs_fall < 0 && bus.vsync === 1'b0) vs_fall = cyc;
        end
    endtask

    initial begin : monitor
        exp_t e, got;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                got = '{cx: bus.counter_x, cy: bus.counter_y, hs: bus.hsync, vs: bus.vsync,
                        vid: bus.video_on, ft: bus.frame_tick, rgb: bus.rgb};
                n_chk = n_chk + 1;
                if (got === e) n_pass = n_pass + 1;
                else $display("FAIL pixel cyc=%0d t=%0t got cx=%0d cy=%0d hs=%b vs=%b vid=%b ft=%b rgb=%h expected cx=%0d cy=%0d hs=%b vs=%b vid=%b ft=%b rgb=%h",
                              cyc, $time, got.cx, got.cy, got.hs, got.vs, got.vid, got.ft, got.rgb,
                              e.cx, e.cy, e.hs, e.vs, e.vid, e.ft, e.rgb);
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        bus.draw_ball = 1'b0;
        bus.draw_paddle_l = 1'b0;
        bus.draw_paddle_r = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            q.push_back(exp_at(0));
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run(2 * FR * D + 30 * HT * D);

        // Mid-frame asynchronous reset on line 30 of the third frame.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.push_back(exp_at(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            q.push_back(exp_at(0));
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        track_vs = 1'b1;
        run((VA + VF + VS + 2) * HT * D + 2 * D);

        repeat (2) @(negedge clk);
        n_chk = n_chk + 1;
        if (vs_fall == ((VA + VF) * HT + 2) * D) n_pass = n_pass + 1;
        else $display("FAIL vsync_after_reset got cyc=%0d expected cyc=%0d", vs_fall, ((VA + VF) * HT + 2) * D);
        n_chk = n_chk + 1;
        if (q.size() == 0) n_pass = n_pass + 1;
        else $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_tile_scanner.md
Name: vga_tile_scanner

Overview:
- Raster/timing end of the playfield object interface: generates 640x480@60 VGA timing, drives the 6-bit tile coordinates (counter_x, counter_y) into the ball and paddle blocks, and samples their registered draw_* replies back.
- Composites the draw replies, the walls and the background into 12-bit RGB, with hsync/vsync aligned to the pixels.
- Sits at top level between the object blocks and the VGA pins.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz pixel rate); legal values 2..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- TILE_SHIFT, 4, log2 of the tile size in pixels (16x16 tiles, 40x30 grid).
- WALL_TOP, 5, tile row drawn as the top wall.
- WALL_BOT, 29, tile row drawn as the bottom wall.
- BG_COLOR, 12'h000, background RGB444.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- draw_ball  in  1  ball occupies the presented tile; registered by the producer, valid 1 clk after counter_x/counter_y change.
- draw_paddle_l  in  1  left paddle occupies the presented tile; same timing as draw_ball.
- draw_paddle_r  in  1  right paddle occupies the presented tile; same timing as draw_ball.
- counter_x  out  6  tile column of the current pixel; 63 during blanking.
- counter_y  out  6  tile row of the current pixel; 63 during blanking.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- video_on  out  1  pixel on the rgb output is visible.
- rgb  out  12  RGB444 pixel, {R[3:0],G[3:0],B[3:0]}.
- frame_tick  out  1  1-clk pulse per frame, on the first blanking line.

Behaviour:
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is asserted the cycle div_cnt==CLK_DIV-1.
- Line and frame counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - v_cnt counts 0..V_TOTAL-1, where V_TOTAL = 525.
  - h_cnt advances on pix_en. v_cnt advances on pix_en when h_cnt==H_TOTAL-1.
  - Both wrap to 0; simultaneous h_cnt and v_cnt wrap is the frame boundary.
- Stage 0 (registered on pix_en):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - counter_x = active ? h_cnt>>TILE_SHIFT : 63.
  - counter_y = active ? v_cnt>>TILE_SHIFT : 63.
  - hsync_d0 is low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751.
  - vsync_d0 is low for v_cnt in 490..491.
  - Stage 0 also keeps the tile row for wall detection.
- Stage 1 (registered on the next pix_en):
  - Samples draw_* (already valid, since CLK_DIV>=2).
  - Registers hsync, vsync and video_on from the stage-0 copies.
- Output latency and alignment:
  - Outputs lag h_cnt/v_cnt by exactly 2 pixel periods.
  - rgb/hsync/vsync/video_on lag counter_x/y by exactly 1 pixel period.
  - Sync and pixel data are therefore mutually aligned.
- Colour priority, first match wins:
  - !video_on -> 12'h000.
  - draw_ball -> 12'hFFF.
  - draw_paddle_l -> 12'hF00.
  - draw_paddle_r -> 12'h00F.
  - tile row == WALL_TOP or WALL_BOT -> 12'h888.
  - otherwise BG_COLOR.
- Blanking: draw_* inputs are ignored whenever video_on=0.
- frame_tick: high for one clk, on the pix_en cycle where h_cnt==0 and v_cnt==V_ACTIVE.
- Reset, including assertion mid-frame:
  - div_cnt, h_cnt, v_cnt, all pipeline registers -> 0.
  - counter_x = counter_y = 63.
  - hsync = vsync = 1.
  - video_on = 0, rgb = 0, frame_tick = 0.
  - After release, the first pix_en starts line 0, pixel 0.
- Widths: h_cnt and v_cnt are 10 bits; the tile index is h_cnt[9:4] (fits in 6 bits since 639>>4 = 39).

Decomposition:
- Shared package pong_pkg:
  - VGA timing constants and H_TOTAL/V_TOTAL.
  - Colour constants: COL_BALL, COL_PADL, COL_PADR, COL_WALL.
  - TILE_OFFGRID = 6'd63.
- One natural sub-module, vga_timing: divider, h/v counters, raw sync and active flags.
- The top handles the tile mapping, the 2-stage pipeline and compositing.

Test Plan:
- Line timing: release rst, run 1 line -> hsync low for exactly 96 pix_en periods (384 clk), low starting 2 pixel periods after h_cnt=656. Line period is 3200 clk.
- Frame timing: run 2 frames -> vsync low for 2 lines (6400 clk), frame period 1,680,000 clk. frame_tick pulses once per frame, 1 clk wide.
- Tile mapping: pixel (x=100, y=200) -> counter_x=6, counter_y=12. Horizontal blanking pixel h_cnt=700 -> counter_x=counter_y=63.
- Pixel pipeline: model a ball responding 1 clk later with tile (36,27) -> rgb=FFF for exactly pixels x 576..591 on lines 432..447, aligned to syncs. Both paddles asserted at the same pixel -> F00.
- Walls and priority: tile rows 5 and 29 -> 888. draw_ball on row 5 -> FFF. All draw_* forced high during blanking -> rgb=000, video_on=0.
- Reset mid-frame: assert rst at v_cnt=300 -> outputs go to reset values asynchronously, within the same clk. After release, the next vsync low begins at exactly 490 lines later.
